// File: rtl/iterative_divider_if.sv
// Start/done handshake bundle for the iterative divider.
// The master launches an operation with start/A/B and collects Q/R/div_by_zero
// when done pulses; the slave is the divider itself.
interface iterative_divider_if #(
  parameter int N = 32
) ();
  logic         start;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         busy;
  logic         done;
  logic [N-1:0] Q;
  logic [N-1:0] R;
  logic         div_by_zero;

  modport master (
    output start, A, B,
    input  busy, done, Q, R, div_by_zero
  );

  modport slave (
    input  start, A, B,
    output busy, done, Q, R, div_by_zero
  );
endinterface

// File: rtl/iterative_divider.sv
// Sequential unsigned divider: restoring shift-subtract, one quotient bit per clock.
// An accepted start with a non-zero divisor runs N iterations and then pulses done
// for one cycle; a zero divisor completes on the accepting edge with the
// divide-by-zero flag set, Q all ones and R equal to the dividend.
module iterative_divider #(
  parameter int N = 32
) (
  input  logic                clk,
  input  logic                rst,
  iterative_divider_if.slave  bus
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST_ITER = CW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state;
  logic [N-1:0]  r_d;      // dividend bits shift out the top, quotient bits fill the bottom
  logic [N-1:0]  r_v;      // captured divisor
  logic [N-1:0]  r_p;      // partial remainder; its (N+1)-th bit is always 0 between iterations
  logic [CW-1:0] r_cnt;
  logic [N-1:0]  r_q;
  logic [N-1:0]  r_r;
  logic          r_dbz;
  logic          r_busy;
  logic          r_done;

  logic [N:0]    w_t;
  logic          w_ge;
  logic [N-1:0]  w_diff;
  logic [N-1:0]  w_p_next;
  logic [N-1:0]  w_d_next;
  logic          w_b_zero;

  // Trial value: remainder shifted left with the next dividend bit brought in.
  assign w_t      = {r_p, r_d[N-1]};
  assign w_ge     = (w_t >= {1'b0, r_v});
  // When w_ge holds the true difference fits in N bits, so the wrap-around drop of
  // the top bit is exact.
  assign w_diff   = w_t[N-1:0] - r_v;
  assign w_p_next = w_ge ? w_diff : w_t[N-1:0];
  assign w_d_next = {r_d[N-2:0], w_ge};
  assign w_b_zero = (bus.B == {N{1'b0}});

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.Q           = r_q;
  assign bus.R           = r_r;
  assign bus.div_by_zero = r_dbz;

  // Control FSM and datapath: accept/launch, iterate, and publish results on completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_d     <= {N{1'b0}};
      r_v     <= {N{1'b0}};
      r_p     <= {N{1'b0}};
      r_cnt   <= {CW{1'b0}};
      r_q     <= {N{1'b0}};
      r_r     <= {N{1'b0}};
      r_dbz   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            if (w_b_zero) begin
              r_q     <= {N{1'b1}};
              r_r     <= bus.A;
              r_dbz   <= 1'b1;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_DONE;
            end else begin
              r_d     <= bus.A;
              r_v     <= bus.B;
              r_p     <= {N{1'b0}};
              r_cnt   <= {CW{1'b0}};
              r_busy  <= 1'b1;
              r_state <= S_RUN;
            end
          end else begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_d   <= w_d_next;
          r_p   <= w_p_next;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == LAST_ITER) begin
            r_q     <= w_d_next;
            r_r     <= w_p_next;
            r_dbz   <= 1'b0;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_DONE;
          end else begin
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iterative_divider.sv
// Bench for iterative_divider: an N=8 instance checked every cycle against an
// arithmetic model plus literal expectations, and an N=32 instance run with
// back-to-back starts and checked on the division identity and pulse spacing.
module tb_iterative_divider;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  iterative_divider_if #(.N(8))  bus8 ();
  iterative_divider_if #(.N(32)) bus32 ();

  iterative_divider #(.N(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));
  iterative_divider #(.N(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32));

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0d expected=%0d at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model of the N=8 instance: a result appears N edges after an
  // accepted non-zero-divisor start, or on the accepting edge for a zero divisor.
  logic       m_busy = 1'b0;
  logic       m_done = 1'b0;
  logic       m_dbz  = 1'b0;
  logic [7:0] m_q    = 8'd0;
  logic [7:0] m_r    = 8'd0;
  logic [7:0] m_a    = 8'd0;
  logic [7:0] m_b    = 8'd0;
  int         m_left = 0;

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        m_busy = 1'b0; m_done = 1'b0; m_dbz = 1'b0;
        m_q = 8'd0; m_r = 8'd0; m_left = 0;
      end else begin
        m_done = 1'b0;
        if (m_busy) begin
          m_left--;
          if (m_left == 0) begin
            m_busy = 1'b0;
            m_done = 1'b1;
            m_q    = m_a / m_b;
            m_r    = m_a % m_b;
            m_dbz  = 1'b0;
          end
        end else if (bus8.start) begin
          if (bus8.B == 8'd0) begin
            m_done = 1'b1;
            m_q    = 8'hFF;
            m_r    = bus8.A;
            m_dbz  = 1'b1;
          end else begin
            m_a    = bus8.A;
            m_b    = bus8.B;
            m_busy = 1'b1;
            m_left = 8;
          end
        end
      end
    end
  end

  // Per-cycle comparison of every N=8 output against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        check("cyc_busy", bus8.busy, m_busy);
        check("cyc_done", bus8.done, m_done);
        check("cyc_q", bus8.Q, m_q);
        check("cyc_r", bus8.R, m_r);
        check("cyc_dbz", bus8.div_by_zero, m_dbz);
      end
    end
  end

  task automatic start8(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    bus8.A = a; bus8.B = b; bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
  endtask

  // Waits (bounded) for done; returns cycles waited and how many of them had busy high.
  task automatic wait8(output int busy_cyc, output int wait_cyc);
    busy_cyc = 0;
    wait_cyc = 0;
    while (!bus8.done && wait_cyc < 40) begin
      if (bus8.busy) busy_cyc++;
      wait_cyc++;
      @(negedge clk);
    end
    check("done8_seen", bus8.done, 1);
  endtask

  task automatic expect8(input string tag, input logic [7:0] q, input logic [7:0] r, input logic dbz);
    check({tag, "_q"}, bus8.Q, q);
    check({tag, "_r"}, bus8.R, r);
    check({tag, "_dbz"}, bus8.div_by_zero, dbz);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int bc, wc, cnt, seen;
    logic [31:0] a32, b32;
    logic [63:0] lhs;

    rst = 1'b1;
    bus8.start = 1'b0;  bus8.A = 8'd0;   bus8.B = 8'd0;
    bus32.start = 1'b0; bus32.A = 32'd0; bus32.B = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_busy", bus8.busy, 0);
    check("rst_done", bus8.done, 0);
    expect8("rst", 8'd0, 8'd0, 1'b0);
    rst = 1'b0;
    cmp_en = 1'b1;

    // 100 / 7
    start8(8'd100, 8'd7);
    wait8(bc, wc);
    check("t1_busy_cycles", bc, 8);
    check("t1_latency", wc, 8);
    expect8("t1", 8'd14, 8'd2, 1'b0);
    check("pin_model_q", m_q, 14);
    check("pin_model_r", m_r, 2);

    // 255 / 1 and divisor larger than dividend
    start8(8'd255, 8'd1);
    wait8(bc, wc);
    expect8("t2a", 8'd255, 8'd0, 1'b0);
    start8(8'd5, 8'd9);
    wait8(bc, wc);
    expect8("t2b", 8'd0, 8'd5, 1'b0);
    check("pin_model_r2", m_r, 5);

    // divide by zero, then a normal divide clears the flag
    start8(8'd200, 8'd0);
    wait8(bc, wc);
    check("t3_busy_cycles", bc, 0);
    check("t3_latency", wc, 0);
    expect8("t3", 8'd255, 8'd200, 1'b1);
    check("pin_model_dbz", m_dbz, 1);
    start8(8'd9, 8'd3);
    wait8(bc, wc);
    expect8("t3b", 8'd3, 8'd0, 1'b0);

    // start during RUN is ignored; operand changes after capture have no effect
    start8(8'd100, 8'd7);
    @(negedge clk);
    bus8.start = 1'b1; bus8.A = 8'd1; bus8.B = 8'd1;
    @(negedge clk);
    bus8.start = 1'b0; bus8.A = 8'd77; bus8.B = 8'd3;
    wait8(bc, wc);
    expect8("t4", 8'd14, 8'd2, 1'b0);
    repeat (12) @(negedge clk);
    check("t4_no_second", bus8.busy, 0);

    // reset mid-RUN, with a coincident start that must be ignored
    start8(8'd100, 8'd7);
    repeat (3) @(negedge clk);
    rst = 1'b1; bus8.start = 1'b1; bus8.A = 8'd50; bus8.B = 8'd6;
    @(negedge clk);
    rst = 1'b0; bus8.start = 1'b0;
    check("t5_busy", bus8.busy, 0);
    check("t5_done", bus8.done, 0);
    expect8("t5_rst", 8'd0, 8'd0, 1'b0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus8.done || bus8.busy) seen++;
    end
    check("t5_discarded", seen, 0);
    start8(8'd50, 8'd6);
    wait8(bc, wc);
    expect8("t5", 8'd8, 8'd2, 1'b0);

    // N=32 back-to-back with start held high through DONE
    @(negedge clk);
    bus32.start = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i == 0) begin
        a32 = 32'hFFFF_FFFF; b32 = 32'd1;
      end else if (i == 1) begin
        a32 = 32'd12345; b32 = 32'hF000_0000;
      end else begin
        a32 = $urandom;
        b32 = (i % 2 == 0) ? $urandom_range(1, 65535) : ($urandom | 32'd1);
      end
      bus32.A = a32;
      bus32.B = b32;
      cnt = 0;
      do begin
        @(negedge clk);
        cnt++;
      end while (!bus32.done && cnt < 40);
      check("d32_seen", bus32.done, 1);
      check("d32_spacing", cnt, 33);
      lhs = 64'(bus32.Q) * 64'(b32) + 64'(bus32.R);
      check("d32_identity", lhs, 64'(a32));
      check("d32_r_lt_b", (bus32.R < b32), 1);
      check("d32_dbz", bus32.div_by_zero, 0);
    end
    bus32.start = 1'b0;
    repeat (3) @(negedge clk);
    check("d32_idle_busy", bus32.busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
